fifoc2mac: RTL and testbench



---
 rtl/fifoc2mac.sv | 126 ++++++++++++
 tb/tb_fifoc2mac.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifoc2mac.sv
// UDP transmit-side FIFO reader: waits for a full packet in the payload FIFO,
// requests a MAC transmit slot, then streams exactly tx_len bytes to udp_txd.
module fifoc2mac #(
  parameter int LEN_W   = 12,
  parameter int MAX_LEN = 1472
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             fs,
  output logic             fd,
  input  logic [LEN_W-1:0] tx_len,
  output logic             err,
  input  logic [7:0]       fifo_rxd,
  output logic             fifo_rxen,
  input  logic [LEN_W:0]   fifo_cnt,
  output logic             flag_udp_tx_req,
  input  logic             flag_udp_tx_prep,
  output logic [15:0]      udp_tx_len,
  output logic             udp_txen,
  output logic [7:0]       udp_txd
);

  typedef enum logic [2:0] {
    S_IDLE, S_LATCH, S_WAIT_DATA, S_REQ, S_SEND, S_DRAIN, S_DONE
  } state_t;

  state_t           state_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] cnt_q;
  logic             fd_q;
  logic             err_q;
  logic             req_q;
  logic             rxen_q;
  logic             rdv_q;
  logic             txen_q;
  logic [7:0]       txd_q;
  logic [15:0]      txlen_q;
  logic             len_ok;

  assign len_ok = (tx_len != '0) && (tx_len <= LEN_W'(MAX_LEN));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      fd_q    <= 1'b0;
      err_q   <= 1'b0;
      req_q   <= 1'b0;
      rxen_q  <= 1'b0;
      rdv_q   <= 1'b0;
      txen_q  <= 1'b0;
      txd_q   <= 8'h00;
      txlen_q <= 16'h0000;
    end else begin
      // FIFO data arrives one cycle after the read; one more register stage to the MAC.
      rdv_q  <= rxen_q;
      txen_q <= rdv_q;
      txd_q  <= rdv_q ? fifo_rxd : 8'h00;

      case (state_q)
        S_IDLE: begin
          if (fs) state_q <= S_LATCH;
        end
        S_LATCH: begin
          len_q   <= tx_len;
          txlen_q <= {{(16-LEN_W){1'b0}}, tx_len};
          if (!len_ok) begin
            err_q   <= 1'b1;
            fd_q    <= 1'b1;
            state_q <= S_DONE;
          end else begin
            state_q <= S_WAIT_DATA;
          end
        end
        S_WAIT_DATA: begin
          if (fifo_cnt >= {1'b0, len_q}) begin
            req_q   <= 1'b1;
            state_q <= S_REQ;
          end
        end
        S_REQ: begin
          if (flag_udp_tx_prep) begin
            req_q   <= 1'b0;
            rxen_q  <= 1'b1;
            cnt_q   <= '0;
            state_q <= S_SEND;
          end
        end
        S_SEND: begin
          cnt_q <= cnt_q + LEN_W'(1);
          if (cnt_q == len_q - LEN_W'(1)) begin
            rxen_q  <= 1'b0;
            state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          // rdv_q low means the final byte is on udp_txd this cycle.
          if (!rdv_q) begin
            fd_q    <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          if (!fs) begin
            fd_q    <= 1'b0;
            err_q   <= 1'b0;
            txlen_q <= 16'h0000;
            cnt_q   <= '0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign fd              = fd_q;
  assign err             = err_q;
  assign fifo_rxen       = rxen_q;
  assign flag_udp_tx_req = req_q;
  assign udp_tx_len      = txlen_q;
  assign udp_txen        = txen_q;
  assign udp_txd         = txd_q;

endmodule

// File: tb/tb_fifoc2mac.sv
// Directed/randomised bench for fifoc2mac with a queue-based FIFO and MAC grant model.
module tb_fifoc2mac;

  localparam int LEN_W = 12;
  localparam int MAX_LEN = 1472;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             fs;
  logic             fd;
  logic [LEN_W-1:0] tx_len;
  logic             err;
  logic [7:0]       fifo_rxd;
  logic             fifo_rxen;
  logic [LEN_W:0]   fifo_cnt;
  logic             flag_udp_tx_req;
  logic             flag_udp_tx_prep;
  logic [15:0]      udp_tx_len;
  logic             udp_txen;
  logic [7:0]       udp_txd;

  fifoc2mac #(.LEN_W(LEN_W), .MAX_LEN(MAX_LEN)) dut (
    .clk(clk), .rst_n(rst_n), .fs(fs), .fd(fd), .tx_len(tx_len), .err(err),
    .fifo_rxd(fifo_rxd), .fifo_rxen(fifo_rxen), .fifo_cnt(fifo_cnt),
    .flag_udp_tx_req(flag_udp_tx_req), .flag_udp_tx_prep(flag_udp_tx_prep),
    .udp_tx_len(udp_tx_len), .udp_txen(udp_txen), .udp_txd(udp_txd)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // FIFO model: read data valid the cycle after fifo_rxen
  logic [7:0]     fq[$];
  logic [7:0]     exp_q[$];
  logic           ovr_en = 1'b0;
  logic [LEN_W:0] ovr = '0;

  initial begin
    fifo_rxd = 8'h00;
    fifo_cnt = '0;
  end

  always @(posedge clk) begin
    logic [7:0] b;
    b = 8'h00;
    if (fifo_rxen && fq.size() > 0) b = fq.pop_front();
    if (fifo_rxen) fifo_rxd <= b;
    fifo_cnt <= ovr_en ? ovr : (LEN_W+1)'(fq.size());
  end

  // Monitor and MAC grant responder, sampled on the falling edge
  logic [7:0] tx_q[$];
  int cyc = 0, tx_n, tx_first, tx_last, rx_n, rx_first, rx_last;
  int req_n, req_last, fd_n, fd_rise, err_n, age, prep_dly = 2;
  logic [15:0] len_at_req;

  initial flag_udp_tx_prep = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (udp_txen) begin
      tx_q.push_back(udp_txd);
      if (tx_n == 0) tx_first = cyc;
      tx_last = cyc;
      tx_n++;
    end else if (rst_n === 1'b1) begin
      chk("txd_idle_zero", 32'(udp_txd), 0);
    end
    if (fifo_rxen) begin
      if (rx_n == 0) rx_first = cyc;
      rx_last = cyc;
      rx_n++;
    end
    if (flag_udp_tx_req) begin
      req_n++;
      req_last = cyc;
      len_at_req = udp_tx_len;
      age++;
      flag_udp_tx_prep = (age >= prep_dly);
    end else begin
      age = 0;
      flag_udp_tx_prep = 1'b0;
    end
    if (fd) begin
      fd_n++;
      if (fd_rise < 0) fd_rise = cyc;
    end
    if (err) err_n++;
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_mon();
    tx_q.delete();
    tx_n = 0; tx_first = -1; tx_last = -1;
    rx_n = 0; rx_first = -1; rx_last = -1;
    req_n = 0; req_last = -1; fd_n = 0; fd_rise = -1; err_n = 0;
    len_at_req = 16'h0;
  endtask

  task automatic wait_fd(input int bound);
    for (int i = 0; i < bound && fd_rise < 0; i++) step();
    chk("fd_timeout", 32'(fd_rise >= 0), 1);
  endtask

  // One legal packet. hold>0 keeps fifo_cnt at 10 for hold cycles first.
  task automatic run_pkt(input int len, input int dly, input int hold,
                         input bit incr, input bit early, input int extra);
    clear_mon();
    prep_dly = dly;
    exp_q.delete();
    for (int i = 0; i < len; i++) begin
      logic [7:0] b;
      b = incr ? 8'(i) : 8'($urandom);
      fq.push_back(b);
      exp_q.push_back(b);
    end
    if (hold > 0) begin ovr = 10; ovr_en = 1'b1; end
    tx_len = LEN_W'(len);
    step();
    fs = 1'b1;
    if (hold > 0) begin
      repeat (hold) step();
      chk("underfill_no_req", 32'(req_n), 0);
      chk("underfill_no_read", 32'(rx_n), 0);
      chk("underfill_req_low", 32'(flag_udp_tx_req), 0);
      chk("underfill_len_out", 32'(udp_tx_len), 32'(len));
      ovr_en = 1'b0;
    end
    if (early) begin
      for (int i = 0; i < 200 && req_n == 0; i++) step();
      fs = 1'b0;
    end
    wait_fd(len + hold + 200);
    chk("burst_len", 32'(tx_n), 32'(len));
    chk("burst_contig", 32'(tx_last - tx_first), 32'(len - 1));
    chk("read_len", 32'(rx_n), 32'(len));
    chk("read_contig", 32'(rx_last - rx_first), 32'(len - 1));
    chk("read_to_tx_lat", 32'(tx_first - rx_first), 2);
    chk("send_after_req", 32'(rx_first - req_last), 1);
    chk("req_until_prep", 32'(req_n), 32'(dly));
    chk("len_to_mac", 32'(len_at_req), 32'(len));
    chk("fd_after_last", 32'(fd_rise > tx_last), 1);
    chk("no_err", 32'(err_n), 0);
    for (int i = 0; i < len && i < tx_q.size(); i++)
      chk("payload", 32'(tx_q[i]), 32'(exp_q[i]));
    if (early) begin
      chk("fd_pulse_low", 32'(fd), 0);
      chk("fd_pulse_width", 32'(fd_n), 1);
      chk("len_cleared", 32'(udp_tx_len), 0);
    end else begin
      repeat (extra) step();
      chk("fd_held", 32'(fd), 1);
      chk("no_restart", 32'(req_n), 32'(dly));
      chk("len_held", 32'(udp_tx_len), 32'(len));
      fs = 1'b0;
      step();
      chk("fd_cleared", 32'(fd), 0);
      chk("len_cleared", 32'(udp_tx_len), 0);
    end
    step();
  endtask

  task automatic run_bad(input int len);
    clear_mon();
    tx_len = LEN_W'(len);
    step();
    fs = 1'b1;
    wait_fd(50);
    chk("bad_err", 32'(err), 1);
    chk("bad_fd", 32'(fd), 1);
    chk("bad_len_out", 32'(udp_tx_len), 32'(len));
    chk("bad_no_req", 32'(req_n), 0);
    chk("bad_no_read", 32'(rx_n), 0);
    chk("bad_no_tx", 32'(tx_n), 0);
    fs = 1'b0;
    step();
    chk("bad_fd_clear", 32'(fd), 0);
    chk("bad_err_clear", 32'(err), 0);
    step();
  endtask

  initial begin
    rst_n = 1'b0;
    fs = 1'b0;
    tx_len = '0;
    clear_mon();
    repeat (3) step();
    chk("reset_outputs", 32'({fd, err, fifo_rxen, flag_udp_tx_req, udp_txen, udp_txd, udp_tx_len}), 0);
    rst_n = 1'b1;
    step();

    // nominal 4-byte packet A1..A4, grant after 2 cycles
    clear_mon();
    prep_dly = 2;
    exp_q.delete();
    fq.delete();
    for (int i = 0; i < 4; i++) begin
      fq.push_back(8'hA1 + 8'(i));
      exp_q.push_back(8'hA1 + 8'(i));
    end
    tx_len = 4;
    step();
    fs = 1'b1;
    wait_fd(100);
    chk("nom_burst_len", 32'(tx_n), 4);
    chk("nom_contig", 32'(tx_last - tx_first), 3);
    chk("nom_reads", 32'(rx_n), 4);
    chk("nom_req_cycles", 32'(req_n), 2);
    chk("nom_len", 32'(udp_tx_len), 4);
    for (int i = 0; i < 4 && i < tx_q.size(); i++)
      chk("nom_payload", 32'(tx_q[i]), 32'(exp_q[i]));
    chk("nom_fd", 32'(fd), 1);
    fs = 1'b0;
    step();
    chk("nom_fd_clear", 32'(fd), 0);
    step();

    run_bad(0);
    run_bad(MAX_LEN + 1);
    run_bad($urandom_range(MAX_LEN + 2, 4095));

    run_pkt(64, 3, 30, 1'b1, 1'b0, 2);
    run_pkt(MAX_LEN, $urandom_range(1, 4), 0, 1'b0, 1'b0, 1);
    run_pkt(1, $urandom_range(1, 4), 0, 1'b0, 1'b0, 3);
    for (int n = 0; n < 4; n++)
      run_pkt($urandom_range(1, 200), $urandom_range(1, 4), 0, 1'b0, n[0], $urandom_range(0, 5));

    // reset during a 100-byte burst
    clear_mon();
    prep_dly = 2;
    for (int i = 0; i < 100; i++) fq.push_back(8'($urandom));
    tx_len = 100;
    step();
    fs = 1'b1;
    for (int i = 0; i < 400 && tx_n < 20; i++) step();
    chk("reached_byte20", 32'(tx_n >= 20), 1);
    rst_n = 1'b0;
    #1;
    chk("midsend_reset_outputs", 32'({fd, err, fifo_rxen, flag_udp_tx_req, udp_txen, udp_txd, udp_tx_len}), 0);
    fs = 1'b0;
    fq.delete();
    repeat (3) step();
    rst_n = 1'b1;
    step();
    run_pkt(8, 2, 0, 1'b0, 1'b0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
